// File: rtl/channel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : channel_pkg
// Description : Shared constants and types for the square-wave channel.
//               c_sample_width : default width of volume/duty/period/wave
//               sample_t       : one sample at the default width
// Revision    : 1.0 - initial release
// ============================================================================
package channel_pkg;

   localparam int unsigned c_sample_width = 16;

   typedef logic [c_sample_width-1:0] sample_t;

endpackage : channel_pkg
`default_nettype wire

// File: rtl/channel_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : channel_phase_counter
// Description : Free-running phase counter for one square-wave period.
//               Steps 0..period-1, then returns to 0. period==0 holds it at 0.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous active-high reset
//               period - period length in clocks (unsigned)
//               cnt    - current phase
// Revision    : 1.0 - initial release
// ============================================================================
module channel_phase_counter
   import channel_pkg::*;
#(
   parameter int WIDTH = c_sample_width
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] r_cnt;
   logic             w_wrap;
   logic [WIDTH-1:0] w_cnt_next;

   // ">=" rather than "==" so that a period shrinking below the current phase
   // wraps on the next clock instead of running up to the counter limit.
   // The period==0 term guards the subtraction, so it never underflows into
   // the decision.
   always_comb begin
      w_wrap     = (period == '0) || (r_cnt >= (period - WIDTH'(1)));
      w_cnt_next = w_wrap ? '0 : (r_cnt + WIDTH'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

   assign cnt = r_cnt;

endmodule : channel_phase_counter
`default_nettype wire

// File: rtl/channel.sv
`default_nettype none
// ============================================================================
// Module      : channel
// Description : Registered square-wave generator. Outputs volume while the
//               phase is below duty_cycle, else 0; one clock of latency.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               volume     - amplitude during the high phase (unsigned)
//               duty_cycle - high-phase clocks per period (unsigned)
//               period     - period length in clocks (unsigned, 0 = silent)
//               wave       - registered output sample
// Revision    : 1.0 - initial release
// ============================================================================
module channel
   import channel_pkg::*;
#(
   parameter int WIDTH = c_sample_width
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] volume,
   input  logic [WIDTH-1:0] duty_cycle,
   input  logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] wave
);

   logic [WIDTH-1:0] w_cnt;
   logic [WIDTH-1:0] w_wave_next;
   logic [WIDTH-1:0] r_wave;

   channel_phase_counter #(
      .WIDTH (WIDTH)
   ) u_phase_counter (
      .clk    (clk),
      .rst    (rst),
      .period (period),
      .cnt    (w_cnt)
   );

   // Inputs are used live: a new volume/duty shows up on the very next sample.
   always_comb begin
      w_wave_next = '0;
      if ((period != '0) && (w_cnt < duty_cycle)) begin
         w_wave_next = volume;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wave <= '0;
      end else begin
         r_wave <= w_wave_next;
      end
   end

   assign wave = r_wave;

endmodule : channel
`default_nettype wire

// File: tb/tb_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel
// Description : Directed self-checking bench for the square-wave channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel;

   localparam int WIDTH = 16;
   localparam logic [WIDTH-1:0] VOL = 16'hF000;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] volume;
   logic [WIDTH-1:0] duty_cycle;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] wave;

   int n_tests;
   int n_fail;

   channel #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .volume     (volume),
      .duty_cycle (duty_cycle),
      .period     (period),
      .wave       (wave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: inputs are changed and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d);
      period     = p;
      duty_cycle = d;
      volume     = VOL;
      rst        = 1'b1;
      tick();
      tick();
      rst        = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(16'd4, 16'd2);
      n_tests++;
      if (wave !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_wave: got %h expected 0000", wave);
      end
      n_tests++;
      if (dut.u_phase_counter.cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: got %0d expected 0", dut.u_phase_counter.cnt);
      end
   endtask

   task automatic test_steady();
      logic [WIDTH-1:0] exp_w;
      logic [WIDTH-1:0] exp_c;
      do_reset(16'd4, 16'd2);
      for (int i = 0; i < 12; i++) begin
         tick();
         exp_w = ((i % 4) < 2) ? VOL : 16'h0000;
         exp_c = WIDTH'((i + 1) % 4);
         n_tests++;
         if (wave !== exp_w || dut.u_phase_counter.cnt !== exp_c) begin
            n_fail++;
            $display("FAIL steady[%0d]: wave %h cnt %0d expected %h cnt %0d",
                     i, wave, dut.u_phase_counter.cnt, exp_w, exp_c);
         end
      end
   endtask

   task automatic test_duty_extremes();
      logic [WIDTH-1:0] duties [3];
      logic [WIDTH-1:0] exps   [3];
      int bad;
      duties = '{16'd0, 16'd4, 16'd9};
      exps   = '{16'h0000, VOL, VOL};
      for (int k = 0; k < 3; k++) begin
         do_reset(16'd4, duties[k]);
         bad = 0;
         for (int i = 0; i < 8; i++) begin
            tick();
            if (wave !== exps[k]) bad++;
         end
         n_tests++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL duty_extreme duty=%0d: %0d bad samples, last wave %h expected %h",
                     duties[k], bad, wave, exps[k]);
         end
      end
   endtask

   task automatic test_period_zero_one();
      int bad;
      do_reset(16'd0, 16'd2);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wave !== 16'h0000 || dut.u_phase_counter.cnt !== 16'd0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL period_zero: %0d bad samples, wave %h cnt %0d expected 0000 cnt 0",
                  bad, wave, dut.u_phase_counter.cnt);
      end
      do_reset(16'd1, 16'd1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wave !== VOL || dut.u_phase_counter.cnt !== 16'd0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL period_one: %0d bad samples, wave %h cnt %0d expected f000 cnt 0",
                  bad, wave, dut.u_phase_counter.cnt);
      end
   endtask

   task automatic test_period_shrink();
      logic [WIDTH-1:0] exp_c;
      do_reset(16'd10, 16'd5);
      for (int i = 0; i < 7; i++) tick();
      n_tests++;
      if (dut.u_phase_counter.cnt !== 16'd7) begin
         n_fail++;
         $display("FAIL shrink_pre: cnt %0d expected 7", dut.u_phase_counter.cnt);
      end
      period = 16'd4;
      tick();
      // cnt was 7 (>= 5), so this sample is low and the counter wraps.
      n_tests++;
      if (dut.u_phase_counter.cnt !== 16'd0 || wave !== 16'h0000) begin
         n_fail++;
         $display("FAIL shrink_wrap: cnt %0d wave %h expected cnt 0 wave 0000",
                  dut.u_phase_counter.cnt, wave);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_c = WIDTH'((i + 1) % 4);
         n_tests++;
         if (wave !== VOL || dut.u_phase_counter.cnt !== exp_c) begin
            n_fail++;
            $display("FAIL shrink_after[%0d]: wave %h cnt %0d expected f000 cnt %0d",
                     i, wave, dut.u_phase_counter.cnt, exp_c);
         end
      end
   endtask

   // Leaves the DUT at cnt=30000 of a 44100-clock period with duty 22050.
   task automatic test_reset_mid_run();
      int bad;
      do_reset(16'd44100, 16'd22050);
      for (int i = 0; i < 30000; i++) tick();
      n_tests++;
      if (dut.u_phase_counter.cnt !== 16'd30000) begin
         n_fail++;
         $display("FAIL midrun_pre: cnt %0d expected 30000", dut.u_phase_counter.cnt);
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++;
         if (wave !== 16'h0000 || dut.u_phase_counter.cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_in_reset[%0d]: wave %h cnt %0d expected 0000 cnt 0",
                     i, wave, dut.u_phase_counter.cnt);
         end
      end
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 30000; i++) begin
         tick();
         if (wave !== ((i < 22050) ? VOL : 16'h0000)) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL midrun_after: %0d bad samples of 30000", bad);
      end
      n_tests++;
      if (dut.u_phase_counter.cnt !== 16'd30000) begin
         n_fail++;
         $display("FAIL midrun_cnt: cnt %0d expected 30000", dut.u_phase_counter.cnt);
      end
   endtask

   // Continues from cnt=30000: shrink duty mid-period, then check the next period.
   task automatic test_live_duty();
      int bad;
      int highs;
      duty_cycle = 16'd2;
      bad = 0;
      for (int i = 30000; i < 44100; i++) begin
         tick();
         if (wave !== 16'h0000) bad++;
      end
      n_tests++;
      if (bad != 0 || dut.u_phase_counter.cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL live_duty_tail: %0d bad samples, cnt %0d expected 0", bad,
                  dut.u_phase_counter.cnt);
      end
      bad   = 0;
      highs = 0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (wave === VOL) highs++;
         if (wave !== ((i < 2) ? VOL : 16'h0000)) bad++;
      end
      n_tests++;
      if (bad != 0 || highs != 2) begin
         n_fail++;
         $display("FAIL live_duty_next: %0d bad samples, %0d high clocks expected 2", bad, highs);
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst        = 1'b1;
      volume     = '0;
      duty_cycle = '0;
      period     = '0;
      test_reset();
      test_steady();
      test_duty_extremes();
      test_period_zero_one();
      test_period_shrink();
      test_reset_mid_run();
      test_live_duty();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_channel
`default_nettype wire
